// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC angle reduction path.
// Angles enter as signed Q3.29 radians and leave as signed Q2.30 radians.
package cordic_pkg;

  localparam int unsigned THETA_W  = 32;  // angle word width, both formats
  localparam int unsigned IN_FRAC  = 29;  // Q3.29 fraction bits
  localparam int unsigned OUT_FRAC = 30;  // Q2.30 fraction bits
  localparam int unsigned WRAP_W   = 34;  // headroom for +/- 2*pi arithmetic

  localparam logic [31:0] PI_Q29      = 32'h6487ED51;
  localparam logic [31:0] HALF_PI_Q29 = 32'h3243F6A9;
  localparam logic [33:0] TWO_PI_Q29  = 34'h0C90FDAA2;

  // Which reflection the fold stage applied.
  typedef enum logic [1:0] {
    FOLD_NONE = 2'd0,
    FOLD_POS  = 2'd1,
    FOLD_NEG  = 2'd2
  } fold_e;

  // Sign-extend a Q3.29 word into the wide arithmetic format.
  function automatic logic signed [WRAP_W-1:0] sext_q29(input logic [THETA_W-1:0] v);
    return {{(WRAP_W-THETA_W){v[THETA_W-1]}}, v};
  endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// Valid/ready register slice carrying an opaque W-bit payload.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_valid/o_ready  upstream handshake, i_data payload in
//   o_valid/i_ready  downstream handshake, o_data payload out
// The slice loads whenever it is empty or its content is leaving, so a
// full pipeline shifts without bubbles; o_ready never depends on i_valid.
module cordic_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_advance;

  assign w_advance = !r_valid || i_ready;
  assign o_ready   = w_advance;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Payload only updates on a real load, so held data stays stable during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_advance) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Reduces any Q3.29 angle in [-4, 4) to a Q2.30 angle in [-pi/2, pi/2]
// for the CORDIC core, plus a flag telling downstream to negate cos.
// Stage 1 wraps into [-pi, pi]; stage 2 folds into [-pi/2, pi/2] and
// converts format. Both stages are valid/ready slices.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_theta/in_tag        upstream angle interface
//   out_valid/out_ready/out_theta/out_neg_cos/out_tag  downstream interface
module cordic_angle_reducer
  import cordic_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_theta,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_theta,
  output logic               out_neg_cos,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned S1_W = THETA_W + TAG_W;
  localparam int unsigned S2_W = 1 + THETA_W + TAG_W;

  logic signed [WRAP_W-1:0] w_pi;
  logic signed [WRAP_W-1:0] w_half_pi;
  logic signed [WRAP_W-1:0] w_two_pi;

  assign w_pi      = {2'b00, PI_Q29};
  assign w_half_pi = {2'b00, HALF_PI_Q29};
  assign w_two_pi  = TWO_PI_Q29;

  // Stage 1 input: wrap into [-pi, pi]; boundary values pass untouched.
  logic signed [WRAP_W-1:0] w_x;
  logic signed [WRAP_W-1:0] w_wrap;

  always_comb begin
    w_x    = sext_q29(in_theta);
    w_wrap = w_x;
    if (w_x > w_pi) begin
      w_wrap = w_x - w_two_pi;
    end else if (w_x < -w_pi) begin
      w_wrap = w_x + w_two_pi;
    end
  end

  logic             w_s1_valid;
  logic             w_s1_ready;
  logic [S1_W-1:0]  w_s1_din;
  logic [S1_W-1:0]  w_s1_dout;
  logic             w_s2_ready;

  // Wrapped value lies within [-pi, pi], so 32 bits of Q3.29 hold it exactly.
  assign w_s1_din = {w_wrap[THETA_W-1:0], in_tag};

  cordic_pipe_stage #(
    .W (S1_W)
  ) u_stage1 (
    .clk     (clk),
    .rst_n   (rst),
    .i_valid (in_valid),
    .o_ready (w_s1_ready),
    .i_data  (w_s1_din),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_dout)
  );

  assign in_ready = w_s1_ready;

  // Stage 2 input: fold into [-pi/2, pi/2] by reflecting about +/- pi/2.
  logic [THETA_W-1:0]       w_s1_theta;
  logic [TAG_W-1:0]         w_s1_tag;
  logic signed [WRAP_W-1:0] w_y;
  logic signed [WRAP_W-1:0] w_fold;
  fold_e                    w_fold_sel;
  logic                     w_neg_cos;
  logic [THETA_W-1:0]       w_q30;

  assign w_s1_theta = w_s1_dout[TAG_W +: THETA_W];
  assign w_s1_tag   = w_s1_dout[TAG_W-1:0];

  always_comb begin
    w_y        = sext_q29(w_s1_theta);
    w_fold     = w_y;
    w_fold_sel = FOLD_NONE;
    if (w_y > w_half_pi) begin
      w_fold     = w_pi - w_y;
      w_fold_sel = FOLD_POS;
    end else if (w_y < -w_half_pi) begin
      w_fold     = -w_pi - w_y;
      w_fold_sel = FOLD_NEG;
    end
  end

  assign w_neg_cos = (w_fold_sel != FOLD_NONE);
  // Q3.29 -> Q2.30: one left shift; the folded range guarantees no overflow.
  assign w_q30     = {w_fold[THETA_W-2:0], 1'b0};

  logic w_unused;
  assign w_unused = ^{w_wrap[WRAP_W-1:THETA_W], w_fold[WRAP_W-1:THETA_W-1]};

  logic [S2_W-1:0] w_s2_din;
  logic [S2_W-1:0] w_s2_dout;

  assign w_s2_din = {w_neg_cos, w_q30, w_s1_tag};

  cordic_pipe_stage #(
    .W (S2_W)
  ) u_stage2 (
    .clk     (clk),
    .rst_n   (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_din),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_dout)
  );

  assign out_neg_cos = w_s2_dout[S2_W-1];
  assign out_theta   = w_s2_dout[TAG_W +: THETA_W];
  assign out_tag     = w_s2_dout[TAG_W-1:0];

endmodule
